accum_unit: RTL
===============

Name: accum_unit

Overview:
- Parametrised add/subtract accumulator; successor to the fixed 8-bit registered add/sub accumulator.
- Adds:
  - generic width;
  - signed or unsigned overflow interpretation;
  - optional saturation;
  - load and clear operations;
  - valid-qualified input;
  - sticky and per-operation overflow flags.
- Sits in the datapath between the operand register file and the result bus; consumers sample S on out_valid.

Parameters:
- WIDTH, 8, operand and accumulator width in bits (min 2).
- SIGNED, 0, 0 = unsigned two's-complement wrap/carry rules; 1 = signed overflow rules.
- SATURATE, 0, 0 = result wraps on overflow; 1 = result clamps to the representable limit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A/op qualify this cycle.
- op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- A  in  WIDTH  operand.
- S  out  WIDTH  accumulator value.
- out_valid  out  1  one-cycle pulse: S updated at the preceding edge.
- ovf  out  1  overflow pulse for the operation just completed.
- ovf_sticky  out  1  OR of all ovf since reset or last CLEAR.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all registers are 0: stage-1 A/op/valid, S, out_valid, ovf, ovf_sticky.
  - Takes effect without a clock edge. Any in-flight operation is discarded.
- Pipeline, 2 stages, no backpressure:
  - Edge k: A, op and in_valid are captured into stage-1 registers.
  - Edge k+1: the accumulator is updated from the stage-1 values.
  - S, ovf and out_valid reflect that op after edge k+1. Latency is 2 edges from input to S.
  - Throughput is one op per cycle; back-to-back ops chain on the updated S.
- Stage-1 valid = 0: S and ovf_sticky hold; out_valid=0; ovf=0.
- ADD: S <= S + A.
- SUB: S <= S - A.
- Internal math is WIDTH+1 bits.
- Unsigned overflow (SIGNED=0):
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (A > S).
- Signed overflow (SIGNED=1):
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from S.
- Saturation with SATURATE=1 on overflow:
  - Unsigned ADD gives all-ones; unsigned SUB gives 0.
  - Signed overflow gives max positive (0111…1) if the true result is positive, else min negative (1000…0).
  - With SATURATE=0, the result is the low WIDTH bits.
- LOAD: S <= A; ovf=0; ovf_sticky unchanged.
- CLEAR: S <= 0; ovf=0; ovf_sticky <= 0. CLEAR wins over any same-cycle overflow accumulation.
- ovf_sticky <= ovf_sticky | ovf_next on every valid ADD/SUB.
- Sampling: A and op are don't-care when in_valid=0; the block must not propagate X into S in that case.

Decomposition:
- Package accum_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_CLEAR=2'b11;
  - helper functions for WIDTH-dependent max/min constants.
- Sub-module accum_alu: purely combinational, parameters WIDTH/SIGNED/SATURATE.
  - Inputs: acc, operand, op.
  - Outputs: next value, overflow bit.
  - Instantiated once inside accum_unit, between stage 1 and the accumulator register.
- All registers (stage 1, S, flags) live in accum_unit.

Test Plan (WIDTH=8 unless stated):
1. Reset, then in_valid=1 ADD A=0x05 at edge 0 -> S=0x00 after edge 0; S=0x05, out_valid=1, ovf=0 after edge 1; out_valid=0 after edge 2.
2. Unsigned wrap:
   - SATURATE=0: LOAD 0xF0, then ADD 0x20 -> S=0x10, ovf pulse=1, ovf_sticky=1 and held.
   - SATURATE=1: same sequence -> S=0xFF.
   - SUB 0x01 from 0x00 -> S=0xFF with SATURATE=0, 0x00 with SATURATE=1; ovf=1.
3. SIGNED=1, SATURATE=1:
   - LOAD 0x7F, ADD 0x01 -> S=0x7F, ovf=1.
   - LOAD 0x80, SUB 0x01 -> S=0x80, ovf=1.
   - With SATURATE=0, the first case gives S=0x80.
4. Back-to-back, one op per cycle: LOAD 0x10, ADD 0x01, SUB 0x02, idle, CLEAR -> S after successive edges 0x10, 0x11, 0x0F, 0x0F (out_valid=0), 0x00; ovf_sticky=0 after CLEAR.
5. Bubbles: in_valid=0 with A=0xAA, op=ADD toggling for 3 cycles -> S unchanged, out_valid=0, ovf=0.
6. Async reset mid-stream: assert rst_n=0 between edges with an ADD in stage 1 -> S, flags and out_valid go to 0 immediately. After release the dropped op has no effect. WIDTH=16 rerun of scenario 2 with 0xFFF0 + 0x0020 -> S=0x0010, ovf=1.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator: op encodings and width-dependent
// limit helpers used by the ALU for overflow clamping.
package accum_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Widest accumulator the helpers can describe.
  localparam int unsigned MAX_WIDTH = 64;

  // Largest representable value for a given width (all-ones, or 0111..1 when signed).
  function automatic logic [MAX_WIDTH-1:0] max_val(input int unsigned width, input bit is_signed);
    logic [MAX_WIDTH-1:0] ones;
    ones = '1;
    return is_signed ? (ones >> (MAX_WIDTH + 1 - width)) : (ones >> (MAX_WIDTH - width));
  endfunction

  // Smallest representable value as a bit pattern (0, or 1000..0 when signed).
  function automatic logic [MAX_WIDTH-1:0] min_val(input int unsigned width, input bit is_signed);
    logic [MAX_WIDTH-1:0] one;
    one = MAX_WIDTH'(1);
    return is_signed ? (one << (width - 1)) : '0;
  endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational next-value and overflow logic for the accumulator.
// Ports:
//   i_acc     - current accumulator value
//   i_operand - operand A
//   i_op      - operation (ADD/SUB/LOAD/CLEAR)
//   o_next    - value to be written into the accumulator
//   o_ovf     - overflow for this operation (always 0 for LOAD/CLEAR)
module accum_alu
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_operand,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_next,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(max_val(WIDTH, SIGNED));
  localparam logic [WIDTH-1:0] MinVal = WIDTH'(min_val(WIDTH, SIGNED));

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_raw;
  logic             w_ovf;
  logic             w_sat_high;

  // One extra bit exposes carry (add) and borrow (sub) for the unsigned rules.
  assign w_sum  = {1'b0, i_acc} + {1'b0, i_operand};
  assign w_diff = {1'b0, i_acc} - {1'b0, i_operand};

  always_comb begin
    w_raw      = '0;
    w_ovf      = 1'b0;
    w_sat_high = 1'b0;
    unique case (i_op)
      OP_ADD: begin
        w_raw = w_sum[WIDTH-1:0];
        if (SIGNED) begin
          w_ovf = (i_acc[WIDTH-1] == i_operand[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != i_acc[WIDTH-1]);
          // Signed overflow is positive exactly when the accumulator was non-negative.
          w_sat_high = ~i_acc[WIDTH-1];
        end else begin
          w_ovf      = w_sum[WIDTH];
          w_sat_high = 1'b1;
        end
      end
      OP_SUB: begin
        w_raw = w_diff[WIDTH-1:0];
        if (SIGNED) begin
          w_ovf = (i_acc[WIDTH-1] != i_operand[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != i_acc[WIDTH-1]);
          w_sat_high = ~i_acc[WIDTH-1];
        end else begin
          w_ovf      = w_diff[WIDTH];
          w_sat_high = 1'b0;
        end
      end
      OP_LOAD:  w_raw = i_operand;
      OP_CLEAR: w_raw = '0;
    endcase
  end

  always_comb begin
    o_next = w_raw;
    if (SATURATE && w_ovf) begin
      o_next = w_sat_high ? MaxVal : MinVal;
    end
  end

  assign o_ovf = w_ovf;

endmodule

// File: rtl/accum_unit.sv
// Two-stage add/subtract accumulator with load/clear, optional saturation and
// sticky overflow. Operands are registered in stage 1; the accumulator is
// updated from stage 1 on the following edge.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - qualifies op/A this cycle
//   op, A       - operation and operand
//   S           - accumulator value
//   out_valid   - pulse: S was updated at the preceding edge
//   ovf         - overflow pulse for the op just completed
//   ovf_sticky  - OR of ovf since reset or the last CLEAR
module accum_unit
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] S,
  output logic             out_valid,
  output logic             ovf,
  output logic             ovf_sticky
);

  logic             r_valid;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_s;
  logic             r_out_valid;
  logic             r_ovf;
  logic             r_sticky;

  logic [WIDTH-1:0] w_next;
  logic             w_ovf;

  accum_alu #(
    .WIDTH    (WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_alu (
    .i_acc     (r_s),
    .i_operand (r_a),
    .i_op      (r_op),
    .o_next    (w_next),
    .o_ovf     (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_s         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      // Only capture A/op when qualified so undriven inputs never reach S.
      if (in_valid) begin
        r_op <= op;
        r_a  <= A;
      end
      r_out_valid <= r_valid;
      r_ovf       <= r_valid & w_ovf;
      if (r_valid) begin
        r_s <= w_next;
        if (r_op == OP_CLEAR) begin
          r_sticky <= 1'b0;
        end else begin
          r_sticky <= r_sticky | w_ovf;
        end
      end
    end
  end

  assign S          = r_s;
  assign out_valid  = r_out_valid;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule
